// File: rtl/regfile_112_pkg.sv
// Shared widths, reset value and word/address types for regfile_112.
package regfile_112_pkg;

    localparam int unsigned DATA_W_DEF = 8;
    localparam int unsigned ADDR_W_DEF = 2;
    localparam logic [DATA_W_DEF-1:0] RESET_VAL_DEF = '0;

    typedef logic [DATA_W_DEF-1:0] word_t;
    typedef logic [ADDR_W_DEF-1:0] addr_t;

endpackage

// File: rtl/regfile_112_cell.sv
// One storage word: async active-high reset to RESET_VAL, synchronous load.
module regfile_112_cell #(
    parameter int unsigned DATA_W = 8,
    parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Word register; reset wins over load on every edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q <= RESET_VAL;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_112.sv
// Register file with one shared read/write address, synchronous write and
// combinational read. Optional write-first forwarding: REGFILE_WR_BYPASS_EN.
module regfile_112
    import regfile_112_pkg::*;
#(
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter logic [DATA_W-1:0] RESET_VAL = DATA_W'(RESET_VAL_DEF)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wEn,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] din,
    output logic [DATA_W-1:0] dout
);

    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0]  load;
    logic [DATA_W-1:0] words [DEPTH];
    logic [DATA_W-1:0] rd_data;

    // Per-word cells with one-hot load enables decoded from addr and wEn.
    for (genvar i = 0; i < DEPTH; i++) begin : g_word
        assign load[i] = wEn && (addr == ADDR_W'(i));

        regfile_112_cell #(
            .DATA_W   (DATA_W),
            .RESET_VAL(RESET_VAL)
        ) u_cell (
            .clk  (clk),
            .reset(reset),
            .load (load[i]),
            .d    (din),
            .q    (words[i])
        );
    end

    // Stored-data read mux.
    always_comb begin
        rd_data = words[addr];
    end

    // Output select; forwarding is suppressed while reset is held.
    always_comb begin
`ifdef REGFILE_WR_BYPASS_EN
        dout = (wEn && !reset) ? din : rd_data;
`else
        dout = rd_data;
`endif
    end

endmodule

// File: tb/tb_regfile_112.sv
// Self-checking bench for regfile_112 (default 8-bit x 4 words).
module tb_regfile_112;

    logic       clk;
    logic       reset;
    logic       wEn;
    logic [1:0] addr;
    logic [7:0] din;
    logic [7:0] dout;

    int checks;
    int failures;

    logic [7:0] model [4];
    logic [7:0] sb [$];

    typedef struct {
        logic       we;
        logic [1:0] a;
        logic [7:0] d;
        logic [7:0] exp_after;
    } vec_t;

    vec_t tbl [10];

    regfile_112 dut (
        .clk  (clk),
        .reset(reset),
        .wEn  (wEn),
        .addr (addr),
        .din  (din),
        .dout (dout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] exp_read();
        if (reset) return 8'h00;
`ifdef REGFILE_WR_BYPASS_EN
        if (wEn) return din;
`endif
        return model[addr];
    endfunction

    task automatic check(input string name);
        logic [7:0] e;
        checks++;
        if (sb.size() == 0) begin
            failures++;
            $display("FAIL %s: no expected value queued, dout=%02h", name, dout);
        end else begin
            e = sb.pop_front();
            if (dout !== e) begin
                failures++;
                $display("FAIL %s: dout=%02h required=%02h", name, dout, e);
            end
        end
    endtask

    // Drive inputs, queue the expected read, compare once settled.
    task automatic apply(input logic we, input logic [1:0] a, input logic [7:0] d,
                         input string name);
        wEn  = we;
        addr = a;
        din  = d;
        sb.push_back(exp_read());
        #1;
        check(name);
    endtask

    task automatic tick();
        @(posedge clk);
        if (wEn && !reset) model[addr] = din;
        #1;
    endtask

    task automatic set_reset(input logic v);
        reset = v;
        if (v) for (int i = 0; i < 4; i++) model[i] = 8'h00;
    endtask

    task automatic sweep(input string name);
        for (int i = 0; i < 4; i++) apply(1'b0, 2'(i), din, name);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        for (int i = 0; i < 4; i++) model[i] = 8'hxx;

        tbl[0] = '{1'b1, 2'd0, 8'h11, 8'h11};
        tbl[1] = '{1'b1, 2'd1, 8'h22, 8'h22};
        tbl[2] = '{1'b1, 2'd2, 8'h33, 8'h33};
        tbl[3] = '{1'b1, 2'd3, 8'h44, 8'h44};
        tbl[4] = '{1'b0, 2'd0, 8'h99, 8'h11};
        tbl[5] = '{1'b0, 2'd1, 8'h99, 8'h22};
        tbl[6] = '{1'b0, 2'd2, 8'h99, 8'h33};
        tbl[7] = '{1'b0, 2'd3, 8'h99, 8'h44};
        tbl[8] = '{1'b1, 2'd2, 8'h6E, 8'h6E};
        tbl[9] = '{1'b0, 2'd3, 8'hFF, 8'h44};

        // Reset state.
        wEn = 1'b0; addr = 2'd0; din = 8'h00;
        set_reset(1'b1);
        #2;
        sweep("reset_state");
        tick();
        set_reset(1'b0);

        // Write 0xAA to word 1, then reset between edges clears immediately.
        apply(1'b1, 2'd1, 8'hAA, "aa_pre_edge");
        tick();
        apply(1'b0, 2'd1, 8'hAA, "aa_written");
        #2;
        set_reset(1'b1);
        sweep("reset_clear");

        // Writes blocked during reset.
        apply(1'b1, 2'd2, 8'h6D, "blocked_6d_pre");
        tick();
        apply(1'b1, 2'd2, 8'h6E, "blocked_6e_pre");
        tick();
        tick();
        apply(1'b0, 2'd2, 8'h6E, "blocked_word2");

        // Release reset away from an edge, then write 0x6E to word 2.
        #2;
        set_reset(1'b0);
        apply(1'b1, 2'd2, 8'h6E, "post_reset_pre_edge");
        tick();
        apply(1'b0, 2'd2, 8'h6E, "post_reset_word2");
        apply(1'b0, 2'd0, 8'h6E, "post_reset_word0");
        apply(1'b0, 2'd1, 8'h6E, "post_reset_word1");
        apply(1'b0, 2'd3, 8'h6E, "post_reset_word3");

        // Table: independent writes, combinational reads, enable-low hold.
        foreach (tbl[i]) begin
            apply(tbl[i].we, tbl[i].a, tbl[i].d, $sformatf("tbl%0d_pre", i));
            tick();
            wEn = 1'b0;
            sb.push_back(tbl[i].exp_after);
            #1;
            check($sformatf("tbl%0d_post", i));
        end

        // Restore 0x33 in word 2, then hold over 10 idle cycles.
        apply(1'b1, 2'd2, 8'h33, "restore_w2");
        tick();
        wEn = 1'b0;
        for (int i = 0; i < 10; i++) tick();
        sweep("idle_hold");

        // Read-during-write on word 2 holding 0x6E.
        apply(1'b1, 2'd2, 8'h6E, "rdw_setup");
        tick();
        apply(1'b1, 2'd2, 8'h5A, "rdw_before_edge");
        tick();
        apply(1'b0, 2'd2, 8'h5A, "rdw_after_edge");

        // Enable low on word 3 for 5 edges.
        apply(1'b0, 2'd3, 8'hFF, "wen_low_pre");
        for (int i = 0; i < 5; i++) tick();
        apply(1'b0, 2'd3, 8'hFF, "wen_low_word3");

        // Reset asserted between edges aborts a pending write.
        apply(1'b1, 2'd0, 8'h77, "abort_pre");
        #2;
        set_reset(1'b1);
        tick();
        #2;
        set_reset(1'b0);
        apply(1'b0, 2'd0, 8'h77, "abort_word0");
        apply(1'b0, 2'd3, 8'h77, "abort_word3");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
